// File: rtl/ft245_tx.sv
// ---------------------------------------------------------------------------
// ft245_tx
//
// Transmit half of the FT245 asynchronous-FIFO bridge. Bytes arrive from the
// system over a ready/ack handshake. They are held in a small circular buffer
// and then written into the FT245 TX FIFO. The WR strobe, the bus output
// enable and the data hold are all timed in clock cycles derived from
// CLOCK_PERIOD_NS.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   tx_data_si   in   8-bit byte offered by the system
//   tx_rdy_si    in   tx_data_si is valid
//   tx_ack_si    out  buffer can accept (registered); transfer = rdy & ack
//   txe_245      in   FT245 TXE#, active low, asynchronous to clk
//   wr_245       out  FT245 WR strobe; byte latched on its falling edge
//   tx_data_245  out  8-bit data toward the FT245 bus
//   tx_oe_245    out  drive enable for the tx_data_245 tristate
//   tx_stall     out  TXE# held high past TIMEOUT_CYCLES
//
// Optional feature macro: FT245_TX_TIMEOUT_EN
//   When defined, a saturating stall counter drives tx_stall.
//   When undefined, tx_stall is tied to 0 and no counter is built.
//
// If reset is asserted mid-write, wr_245 drops at once and the FT245 may
// still latch that byte. This is accepted behaviour, and the buffer is
// flushed.
// ---------------------------------------------------------------------------
module ft245_tx #(
    parameter int CLOCK_PERIOD_NS = 10,
    parameter int WR_PULSE_NS     = 50,
    parameter int DATA_HOLD_NS    = 10,
    parameter int TXE_WAIT_NS     = 30,
    parameter int FIFO_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_si,
    input  logic       tx_rdy_si,
    output logic       tx_ack_si,
    input  logic       txe_245,
    output logic       wr_245,
    output logic [7:0] tx_data_245,
    output logic       tx_oe_245,
    output logic       tx_stall
);

    function automatic int cyclesFor(input int ns);
        int c;
        c = (ns + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
        return (c < 1) ? 1 : c;
    endfunction

    localparam int WR_CNT   = cyclesFor(WR_PULSE_NS);
    localparam int HOLD_CNT = cyclesFor(DATA_HOLD_NS);
    // The extra two cycles let a TXE# deassertion reach the FSM through the synchronizer
    localparam int REC_CNT  = cyclesFor(TXE_WAIT_NS) + 2;
    localparam int MAX_CNT  = (WR_CNT > HOLD_CNT) ? ((WR_CNT > REC_CNT) ? WR_CNT : REC_CNT)
                                                  : ((HOLD_CNT > REC_CNT) ? HOLD_CNT : REC_CNT);
    localparam int TIMER_W  = $clog2(MAX_CNT + 1);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, STROBE, HOLD, RECOVER} state_t;

    state_t             r_state, w_next_state;
    logic [TIMER_W-1:0] r_timer, w_timer_next;
    logic               w_load, w_pop, w_push;
    logic               r_txe_meta, r_txe_s;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic               r_ack, r_wr, r_oe;
    logic [7:0]         r_data;

    // Two-flop TXE# synchronizer. It resets to 1 so the FT245 is treated as not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txe_meta <= 1'b1;
            r_txe_s    <= 1'b1;
        end else begin
            r_txe_meta <= txe_245;
            r_txe_s    <= r_txe_meta;
        end
    end

    assign w_push = tx_rdy_si & r_ack;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Buffer storage has no reset; the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data_si;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    // Ack is computed from the next count, so it never depends on tx_rdy_si
    // in the same cycle. A full buffer therefore blocks even when a pop
    // happens in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ack    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_ack   <= (w_count_next < CNT_W'(FIFO_DEPTH));
        end
    end

    // Write-cycle sequencer: the decision, the strobe, the data hold and the TXE# recovery.
    always_comb begin
        w_next_state = r_state;
        w_timer_next = r_timer;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) && !r_txe_s) begin
                    w_next_state = STROBE;
                    w_load       = 1'b1;
                    w_timer_next = '0;
                end
            end
            STROBE: begin
                if (r_timer == TIMER_W'(WR_CNT - 1)) begin
                    w_next_state = HOLD;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            HOLD: begin
                if (r_timer == TIMER_W'(HOLD_CNT - 1)) begin
                    w_next_state = RECOVER;
                    w_pop        = 1'b1;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            RECOVER: begin
                if (r_timer == TIMER_W'(REC_CNT - 1)) begin
                    w_next_state = IDLE;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_timer_next = '0;
            end
        endcase
    end

    // The bus outputs are registered from the next state, so they never glitch.
    // Data loads only on entry to STROBE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_wr    <= 1'b0;
            r_oe    <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_timer <= w_timer_next;
            r_wr    <= (w_next_state == STROBE);
            r_oe    <= (w_next_state == STROBE) || (w_next_state == HOLD);
            if (w_load) r_data <= r_mem[r_rd_ptr];
        end
    end

    assign tx_ack_si   = r_ack;
    assign wr_245      = r_wr;
    assign tx_oe_245   = r_oe;
    assign tx_data_245 = r_data;

`ifdef FT245_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_stall;
    logic            w_stalling;

    assign w_stalling = (r_count != '0) && (r_state == IDLE) && r_txe_s;

    // The stall counter saturates at TIMEOUT_CYCLES. The stall flag then holds until the next pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (!w_stalling)
                r_to_cnt <= '0;
            else if (r_to_cnt != TO_W'(TIMEOUT_CYCLES))
                r_to_cnt <= r_to_cnt + 1'b1;
            if (w_pop)
                r_stall <= 1'b0;
            else if (w_stalling && (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1)))
                r_stall <= 1'b1;
        end
    end

    assign tx_stall = r_stall;
`else
    assign tx_stall = 1'b0;
`endif

endmodule

// File: doc/ft245_tx.md
Name: ft245_tx

Overview:
- Transmit half of the FT245 asynchronous-FIFO bridge: takes bytes from the system side over a ready/ack handshake and writes them into the FT245 TX FIFO.
- Generates the WR strobe, the data-bus output enable and the data, timed from CLOCK_PERIOD_NS.
- Buffers up to FIFO_DEPTH bytes so the system side is not stalled by USB back-pressure (TXE# high).
- Sits beside the receive path in the FT245 interface; shares its clock and reset.

Parameters:
- CLOCK_PERIOD_NS, 10, system clock period in ns; all timing counts are ceil(ns / CLOCK_PERIOD_NS), minimum 1.
- WR_PULSE_NS, 50, WR high time; also covers the 20 ns data setup before the WR falling edge.
- DATA_HOLD_NS, 10, data and OE held after the WR falling edge.
- TXE_WAIT_NS, 30, wait after the WR falling edge before TXE# is re-sampled; the synchronizer delay is added on top.
- FIFO_DEPTH, 4, holding-buffer depth in bytes; power of two, 2..16.
- TIMEOUT_CYCLES, 1000000, stall threshold; used only with FT245_TX_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tx_data_si  in  8  byte offered by the system
- tx_rdy_si  in  1  tx_data_si is valid
- tx_ack_si  out  1  buffer can accept; a byte transfers in any cycle where tx_rdy_si=1 and tx_ack_si=1
- txe_245  in  1  FT245 TXE#, active low, asynchronous to clk
- wr_245  out  1  FT245 WR strobe; the byte is latched on its falling edge
- tx_data_245  out  8  data toward the FT245 bus
- tx_oe_245  out  1  bus drive enable for the tx_data_245 tristate
- tx_stall  out  1  TXE# held high past the timeout; constant 0 when the macro is absent

Behaviour:
- Reset values (all asynchronous):
  - wr_245=0, tx_oe_245=0, tx_data_245=0x00, tx_ack_si=0, tx_stall=0.
  - Buffer is empty, FSM is in IDLE, counters are 0.
  - Synchronizer flops reset to 1 (FT245 treated as not ready).
- Reset is asserted mid-write:
  - wr_245 drops immediately, and the FT245 may latch a byte. This is accepted and documented.
  - The buffer is flushed.
- txe_245 passes through a two-flop synchronizer; the FSM sees only the synchronized value txe_s.
- Holding buffer and system handshake:
  - Circular FIFO with a count of 0..FIFO_DEPTH.
  - tx_ack_si = (count < FIFO_DEPTH) and not in reset. It is registered and does not depend combinationally on tx_rdy_si.
  - When full, tx_ack_si=0 even if a pop occurs in the same cycle; the push waits one cycle.
  - Push and pop in the same cycle when not full: count is unchanged, and the pointers wrap modulo FIFO_DEPTH.
  - Bytes leave in arrival order. No byte is dropped or duplicated.
- FSM states:
  - IDLE: wr=0, oe=0. Move to STROBE when count>0 and txe_s=0. On entry to STROBE, load tx_data_245 from the FIFO head.
  - STROBE: wr=1, oe=1, data stable. Stay for the WR_PULSE count, then move to HOLD with wr=0.
  - HOLD: wr=0, oe=1, data stable. Stay for the DATA_HOLD count. At exit, pop the FIFO head and go to RECOVER.
  - RECOVER: wr=0, oe=0. Stay for the TXE_WAIT count + 2 cycles, so the FT245 TXE# deassertion propagates through the synchronizer. Then go to IDLE.
- Default timing (10 ns clock):
  - STROBE lasts 5 cycles, HOLD 1 cycle, RECOVER 5 cycles.
  - Minimum byte period is 11 cycles plus the IDLE decision cycle, i.e. 12 cycles.
- Output glitch rules:
  - tx_data_245 changes only on entry to STROBE.
  - wr_245 never pulses shorter than the WR_PULSE count.
- If txe_s rises while in STROBE or HOLD, the write completes regardless; the FT245 already committed to it when TXE# was low.
- A byte with value 0x00 is transferred like any other byte; there is no in-band framing.

Optional Feature:
- Macro FT245_TX_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each cycle that count>0, the FSM is in IDLE and txe_s=1.
  - The counter clears when any of those conditions is false.
  - tx_stall is set when the counter reaches TIMEOUT_CYCLES and clears on the next successful pop.
  - The counter saturates; it never wraps.
  - Data flow is unaffected.
- Without the macro: no counter is built and tx_stall is tied to 0.

Test Plan:
1. Reset released, txe_245=0, push 0xA5 in one cycle → tx_ack_si=1 after reset; tx_data_245=0xA5 with tx_oe_245=1; wr_245 high for exactly 5 clk; data still 0xA5 for 1 clk after the falling edge.
2. txe_245=1, push 0x01, 0x02, 0x03, 0x04 back-to-back → tx_ack_si drops after the 4th byte and wr_245 stays 0. Release txe_245=0 → four WR pulses with data 01, 02, 03, 04, spaced at least 12 clk apart.
3. tx_rdy_si held at 1 continuously with an incrementing pattern 0x00..0x3F, txe_245=0 → 64 WR pulses with data in order, no gaps or repeats; FIFO pointer wraps verified.
4. Assert rst during STROBE → wr_245, tx_oe_245 and tx_ack_si go to 0 asynchronously, before the next clk edge. After release, a fresh push of 0x5A is written, and no stale byte follows.
5. With FT245_TX_TIMEOUT_EN and TIMEOUT_CYCLES=100: txe_245=1, one byte buffered → tx_stall=1 after 100 stalled clk. Drop txe_245 → byte written and tx_stall=0 after the pop.
6. Toggle txe_245 high during STROBE → the current pulse completes with full width, and the next write waits until txe_s returns to 0.
